sys_arr_mac_driver: RTL

SYS_ARR_MAC_DRIVER -- requirements
Module: sys_arr_mac_driver

---
 rtl/sys_arr_pkg.sv | 24 ++
 rtl/sys_arr_mac_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sys_arr_pkg.sv
// Shared parameters and types for the systolic-array MAC driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sys_arr_pkg;

  localparam int DW      = 16;
  localparam int MUL_LEN = 2;
  localparam int ADD_LEN = 2;
  localparam int LAT     = MUL_LEN + ADD_LEN;
  localparam int CW      = $clog2(MUL_LEN + ADD_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADW = 2'd1,
    RUN   = 2'd2,
    CAPT  = 2'd3
  } mac_drv_state_t;

  // Larger of two widths; used to size counters that must hold both ranges.
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys_arr_mac_driver.sv
// Sequences one MAC cell: weight load, operand issue, latency wait, result capture.
// Latency: weight 1 cycle (LOADW); operand-to-out_valid LAT+2 cycles plus stall cycles.
// Backpressure: in_ready drops while a result is unpopped; stall_in freezes wt/in accept and the count.
module sys_arr_mac_driver
  import sys_arr_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          wt_valid,
  output logic          wt_ready,
  input  logic [DW-1:0] wt_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_acc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          stall_in,
  output logic          err,
  input  logic          clr_err,
  output logic          weight_loaded,
  output logic          mac_start,
  output logic [CW-1:0] mac_count,
  output logic [DW-1:0] mac_in_value,
  output logic          mac_shift,
  output logic [DW-1:0] mac_in_accumulate,
  output logic          mac_weight_en,
  output logic          mac_stall_sa,
  input  logic [DW-1:0] mac_out_accumulate,
  input  logic          mac_value_ready,
  input  logic [DW-1:0] mac_in_pass,
  input  logic          mac_weight_next_en
);

  // The internal counter must reach LAT+TIMEOUT; the MAC only needs to see
  // counts up to its pipeline depth, so the exported count is clipped to CW bits.
  localparam int CNTW = imax(CW, $clog2(LAT + TIMEOUT + 1));
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(LAT + TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAT  = CNTW'(LAT);
  localparam logic [CNTW-1:0] CNT_CLIP = CNTW'((1 << CW) - 1);

  mac_drv_state_t state_q;
  logic [CNTW-1:0] cnt_q;
  logic            out_valid_q, err_q, weight_loaded_q;
  logic [DW-1:0]   out_data_q;
  logic            mac_start_q, mac_shift_q, mac_weight_en_q;
  logic [DW-1:0]   mac_in_value_q, mac_in_accumulate_q;

  logic wt_hs, in_hs, pop, run_done, run_tmo, err_d;

  // MAC monitor outputs carry no information the driver needs.
  logic unused_mac;
  assign unused_mac = ^{mac_in_pass, mac_weight_next_en};

  // Handshake and FSM decision terms.
  always_comb begin
    wt_ready = nRST && (state_q == IDLE) && !stall_in;
    in_ready = nRST && (state_q == IDLE) && weight_loaded_q && !wt_valid && !stall_in &&
               (!out_valid_q || out_ready);
    wt_hs    = wt_valid && wt_ready;
    in_hs    = in_valid && in_ready;
    pop      = out_valid_q && out_ready;
    run_done = (state_q == RUN) && !stall_in && (cnt_q >= CNT_LAT) && mac_value_ready;
    // Give up on the cycle whose increment would land on LAT+TIMEOUT.
    run_tmo  = (state_q == RUN) && !stall_in && !run_done && (cnt_q == CNT_MAX - CNTW'(1));
    // A clear wins over a same-cycle timeout.
    err_d    = clr_err ? 1'b0 : (run_tmo ? 1'b1 : err_q);
  end

  // Control FSM with registered MAC drive and result register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      out_valid_q         <= 1'b0;
      out_data_q          <= '0;
      err_q               <= 1'b0;
      weight_loaded_q     <= 1'b0;
      mac_start_q         <= 1'b0;
      mac_shift_q         <= 1'b0;
      mac_weight_en_q     <= 1'b0;
      mac_in_value_q      <= '0;
      mac_in_accumulate_q <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          // Weight has priority; in_ready is already masked by wt_valid.
          if (wt_hs) begin
            state_q         <= LOADW;
            mac_weight_en_q <= 1'b1;
            mac_shift_q     <= 1'b1;
            mac_in_value_q  <= wt_data;
          end else if (in_hs) begin
            state_q             <= RUN;
            mac_start_q         <= 1'b1;
            mac_in_value_q      <= in_data;
            mac_in_accumulate_q <= in_acc;
            cnt_q               <= '0;
          end
        end
        LOADW: begin
          state_q         <= IDLE;
          mac_weight_en_q <= 1'b0;
          mac_shift_q     <= 1'b0;
          weight_loaded_q <= 1'b1;
        end
        RUN: begin
          mac_start_q <= 1'b0;
          if (run_done) begin
            state_q <= CAPT;
          end else if (run_tmo) begin
            state_q <= IDLE;
            cnt_q   <= CNT_MAX;
          end else if (!stall_in && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        CAPT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Capture beats a same-cycle pop so a back-to-back result is not lost.
      if (state_q == CAPT) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mac_out_accumulate;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign err               = err_q;
  assign weight_loaded     = weight_loaded_q;
  assign mac_start         = mac_start_q;
  assign mac_shift         = mac_shift_q;
  assign mac_weight_en     = mac_weight_en_q;
  assign mac_in_value      = mac_in_value_q;
  assign mac_in_accumulate = mac_in_accumulate_q;
  assign mac_count         = (cnt_q > CNT_CLIP) ? {CW{1'b1}} : cnt_q[CW-1:0];
  assign mac_stall_sa      = nRST && stall_in;

endmodule
